vga_sync_gen: RTL

Generates VGA 640x480@60 Hz raster timing: horizontal/vertical counters, active-low sync pulses, a video-active flag and a frame-start strobe. Sits directly upstream of the pixel-window comparator: its `x`/`y` outputs (10 bit, 0..639 / 0..479 in the active area) drive that stage's current-pixel inputs, and `video_on` gates the RGB path downstream of it.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_sync_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and decode helper for vga_sync_gen
package vga_pkg;

   // Visible area, porches and sync widths (pixels / lines)
   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   // Coordinate width; both totals below must fit in it
   localparam int unsigned VGA_CNT_W    = 10;

   // Derived totals
   localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Sync pulse windows, start inclusive / end exclusive
   localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
   localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

   // Half-open window test used by the sync decoders
   function automatic logic in_window(int unsigned v, int unsigned lo, int unsigned hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters, syncs, video_on and frame_start; VGA_SYNC_CLK_DIV_EN enables a /4 pixel-tick divider
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter int unsigned CNT_W    = VGA_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             pix_tick,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             tick;

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   logic             frame_start_q, frame_start_d;

`ifdef VGA_SYNC_CLK_DIV_EN
   logic [1:0] div_q;
   logic       tick_q;

   // Free-running /4 divider; tick_q is registered so it is high exactly while div_q == 3
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= 2'd0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_q + 2'd1;
         tick_q <= (div_q == 2'd2);
      end
   end

   assign tick = tick_q;
`else
   assign tick = 1'b1;
`endif

   // Next raster position; counters only move on a pixel tick
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
               y_d = '0;
            end else begin
               y_d = y_q + CNT_ONE;
            end
         end else begin
            x_d = x_q + CNT_ONE;
         end
      end
   end

   // Decode from the next position so syncs and video_on line up with the x/y they accompany
   always_comb begin
      hsync_d       = ~in_window(32'(x_d), HS_START, HS_END);
      vsync_d       = ~in_window(32'(y_d), VS_START, VS_END);
      video_on_d    = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
      frame_start_d = tick && (x_d == '0) && (y_d == '0);
   end

   // Output registers; reset parks the raster on the last pixel so the first tick lands on (0,0)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q           <= X_LAST;
         y_q           <= Y_LAST;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
   assign pix_tick    = tick;

endmodule
